divider_seq: RTL and testbench

Sequential radix-2 restoring divider: the inverse-direction companion to the multiplier datapath. It accepts an unsigned dividend/divisor pair on a start strobe and produces quotient and remainder after WIDTH iterations. Each iteration performs one shift, one trial subtract and one conditional restore. The block sits beside the multiplier in the arithmetic core and shares its operand width and its start/done handshake style.

---
 rtl/divider_seq.sv | 114 +++++++++++
 tb/tb_divider_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Sequential radix-2 restoring divider: unsigned quotient/remainder after WIDTH
// shift/trial-subtract iterations, with a one-cycle divide-by-zero fast path.
module divider_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [CW-1:0]    count_r;

  logic [WIDTH:0]   a_sh_s;
  logic [WIDTH-1:0] diff_s;
  logic             borrow_s;
  logic [WIDTH-1:0] a_nxt_s;
  logic [WIDTH-1:0] q_nxt_s;

  // One restoring iteration; the shifted accumulator keeps its carry-out bit so
  // the trial compare stays exact when A is close to M.
  always_comb begin
    a_sh_s   = {a_r, q_r[WIDTH-1]};
    borrow_s = (a_sh_s < {1'b0, m_r});
    diff_s   = a_sh_s[WIDTH-1:0] - m_r;
    if (borrow_s) begin
      a_nxt_s = a_sh_s[WIDTH-1:0];
      q_nxt_s = {q_r[WIDTH-2:0], 1'b0};
    end else begin
      a_nxt_s = diff_s;
      q_nxt_s = {q_r[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM, working registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      m_r         <= {WIDTH{1'b0}};
      count_r     <= {CW{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            if (divisor != {WIDTH{1'b0}}) begin
              a_r     <= {WIDTH{1'b0}};
              q_r     <= dividend;
              m_r     <= divisor;
              count_r <= {CW{1'b0}};
              busy    <= 1'b1;
              state_r <= RUN;
            end else begin
              quotient    <= {WIDTH{1'b1}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state_r     <= DONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_nxt_s;
          q_r     <= q_nxt_s;
          count_r <= count_r + CW'(1);
          if (count_r == CW'(WIDTH - 1)) begin
            quotient    <= q_nxt_s;
            remainder   <= a_nxt_s;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state_r     <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Directed + random bench for divider_seq (WIDTH=8) with a result scoreboard
// popped on every done pulse.
module tb_divider_seq;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor = 8'd0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  int done_cnt = 0;

  divider_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Result monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done === 1'b1) begin
      done_cnt++;
      check("done_has_expectation", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dbz);
      end
    end
  end

  function automatic exp_t model(input logic [7:0] dd, input logic [7:0] dv);
    exp_t e;
    if (dv == 8'd0) begin
      e.q = 8'hFF; e.r = dd; e.dbz = 1'b1;
    end else begin
      e.q = dd / dv; e.r = dd % dv; e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic run_op(input logic [7:0] dd, input logic [7:0] dv);
    int lat;
    int bcnt;
    @(negedge clk);
    dividend = dd; divisor = dv; start = 1'b1;
    sb.push_back(model(dd, dv));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, (dv == 8'd0) ? 0 : WIDTH);
    check("busy_cycles", bcnt, (dv == 8'd0) ? 0 : WIDTH);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_quotient"}, quotient, 0);
    check({tag, "_remainder"}, remainder, 0);
    check({tag, "_dbz"}, div_by_zero, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int gap;
    #2;
    check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(8'd200, 8'd7);
    run_op(8'd255, 8'd1);
    run_op(8'd5, 8'd9);
    run_op(8'd0, 8'd3);
    run_op(8'd255, 8'd255);
    run_op(8'd42, 8'd0);
    run_op(8'd10, 8'd3);

    // start during RUN is ignored, operands may change freely
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd10; start = 1'b1;
    sb.push_back(model(8'd100, 8'd10));
    base = done_cnt;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    dividend = 8'd9; divisor = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = 8'd50; divisor = 8'd3;
    repeat (20) @(negedge clk);
    check("single_done_when_busy", done_cnt - base, 1);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs("midrst");
    base = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("no_done_after_reset", done_cnt - base, 0);
    run_op(8'd17, 8'd5);

    // back-to-back with start held high across the DONE cycle
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    sb.push_back(model(8'd100, 8'd7));
    gap = 0;
    while (done !== 1'b1 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_first_done_seen", done, 1);
    dividend = 8'd99; divisor = 8'd9;
    sb.push_back(model(8'd99, 8'd9));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    gap = 1;
    while (done !== 1'b1 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_done_spacing", gap, WIDTH + 1);
    @(negedge clk);

    // random sweep of nonzero divisors
    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
